// File: rtl/tdma_slot_locator.sv
// TDMA slot locator: splits a TSF timestamp into frame count, slot index and
// in-slot offset using two passes through an external sequential divider.
// First pass: tsf / slot_len gives the absolute slot number and the offset.
// Second pass: slot number / frame_slots gives the frame count and slot index.
module tdma_slot_locator #(
    parameter int unsigned DIV_TIMEOUT = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] tsf_us,
    input  logic [31:0] slot_len_us,
    input  logic [31:0] frame_slots,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] frame_cnt,
    output logic [31:0] slot_idx,
    output logic [31:0] slot_off_us,
    output logic        err,
    output logic        div_enable,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    input  logic        div_done
);

    typedef enum logic [2:0] {
        IDLE,
        DIV1,
        REL1,
        DIV2,
        REL2,
        RESP
    } state_t;

    localparam logic [31:0] TIMEOUT = 32'(DIV_TIMEOUT);

    state_t      state_q,       state_d;
    logic        divEnable_q,   divEnable_d;
    logic [31:0] divA_q,        divA_d;
    logic [31:0] divB_q,        divB_d;
    logic [31:0] frameCnt_q,    frameCnt_d;
    logic [31:0] slotIdx_q,     slotIdx_d;
    logic [31:0] slotOff_q,     slotOff_d;
    logic        err_q,         err_d;
    logic [31:0] waitCnt_q,     waitCnt_d;
    logic [31:0] quot1_q,       quot1_d;
    logic [31:0] frameSlots_q,  frameSlots_d;

    // State and datapath registers; reset clears everything and parks in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            divEnable_q  <= 1'b0;
            divA_q       <= '0;
            divB_q       <= '0;
            frameCnt_q   <= '0;
            slotIdx_q    <= '0;
            slotOff_q    <= '0;
            err_q        <= 1'b0;
            waitCnt_q    <= '0;
            quot1_q      <= '0;
            frameSlots_q <= '0;
        end else begin
            state_q      <= state_d;
            divEnable_q  <= divEnable_d;
            divA_q       <= divA_d;
            divB_q       <= divB_d;
            frameCnt_q   <= frameCnt_d;
            slotIdx_q    <= slotIdx_d;
            slotOff_q    <= slotOff_d;
            err_q        <= err_d;
            waitCnt_q    <= waitCnt_d;
            quot1_q      <= quot1_d;
            frameSlots_q <= frameSlots_d;
        end
    end

    // Next-state logic: sequences the two divisions, the release phases and the timeout.
    always_comb begin
        state_d      = state_q;
        divEnable_d  = divEnable_q;
        divA_d       = divA_q;
        divB_d       = divB_q;
        frameCnt_d   = frameCnt_q;
        slotIdx_d    = slotIdx_q;
        slotOff_d    = slotOff_q;
        err_d        = err_q;
        waitCnt_d    = waitCnt_q;
        quot1_d      = quot1_q;
        frameSlots_d = frameSlots_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    err_d        = 1'b0;
                    frameCnt_d   = '0;
                    slotIdx_d    = '0;
                    slotOff_d    = '0;
                    frameSlots_d = frame_slots;
                    waitCnt_d    = '0;
                    if ((slot_len_us == 32'd0) || (frame_slots == 32'd0)) begin
                        // A zero divisor skips the divider entirely; routing it
                        // through REL2 gives a fixed two-cycle error response.
                        err_d   = 1'b1;
                        state_d = REL2;
                    end else begin
                        divA_d      = tsf_us;
                        divB_d      = slot_len_us;
                        divEnable_d = 1'b1;
                        state_d     = DIV1;
                    end
                end
            end

            DIV1, DIV2: begin
                if (div_done) begin
                    divEnable_d = 1'b0;
                    if (state_q == DIV1) begin
                        quot1_d   = div_quot;
                        slotOff_d = div_rem;
                        state_d   = REL1;
                    end else begin
                        frameCnt_d = div_quot;
                        slotIdx_d  = div_rem;
                        state_d    = REL2;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 32'd1;
                    if (waitCnt_d == TIMEOUT) begin
                        // Give up on the divider and report an error straight away.
                        divEnable_d = 1'b0;
                        err_d       = 1'b1;
                        frameCnt_d  = '0;
                        slotIdx_d   = '0;
                        slotOff_d   = '0;
                        state_d     = RESP;
                    end
                end
            end

            REL1: begin
                if (!div_done) begin
                    divA_d      = quot1_q;
                    divB_d      = frameSlots_q;
                    divEnable_d = 1'b1;
                    waitCnt_d   = '0;
                    state_d     = DIV2;
                end
            end

            REL2: begin
                if (!div_done) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign div_enable  = divEnable_q;
    assign div_a       = divA_q;
    assign div_b       = divB_q;
    assign frame_cnt   = frameCnt_q;
    assign slot_idx    = slotIdx_q;
    assign slot_off_us = slotOff_q;
    assign err         = err_q;

endmodule

// File: doc/tdma_slot_locator.md
TDMA_SLOT_LOCATOR -- requirements
Module: tdma_slot_locator

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 127, the maximum number of cycles to wait for div_done in one division.
REQ-002 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port tsf_us  input  32  current TSF time in microseconds.
REQ-007 SHALL have port slot_len_us  input  32  slot length in microseconds.
REQ-008 SHALL have port frame_slots  input  32  slots per TDMA frame.
REQ-009 SHALL have port rsp_valid  output  1  result present.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port frame_cnt  output  32  the quotient tsf / slot_len / frame_slots.
REQ-012 SHALL have port slot_idx  output  32  slot index within the frame.
REQ-013 SHALL have port slot_off_us  output  32  offset within the current slot, in microseconds.
REQ-014 SHALL have port err  output  1  result invalid (zero divisor or divider timeout).
REQ-015 SHALL have port div_enable  output  1  level request to the external sequential divider.
REQ-016 SHALL have ports div_a and div_b  output  32  dividend and divisor.
REQ-017 SHALL have ports div_quot and div_rem  input  32  divider quotient and remainder.
REQ-018 SHALL have port div_done  input  1  divider result valid; it stays high while div_enable is high and clears after div_enable goes low.

Function
REQ-019 SHALL implement the FSM states IDLE, DIV1, REL1, DIV2, REL2 and RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both 1, and all three operands are registered.
REQ-021 SHALL, on accept with slot_len_us==0 or frame_slots==0, go to RESP with err=1 and all data outputs 0, without asserting div_enable.
REQ-022 SHALL, on any other accept, go IDLE->DIV1 with div_a=tsf, div_b=slot_len and div_enable=1.
REQ-023 SHALL hold div_a and div_b stable while div_enable is high.
REQ-024 SHALL, in DIV1 on div_done=1, capture q1=div_quot and slot_off_us=div_rem, then go to REL1.
REQ-025 SHALL, in REL1 and REL2, drive div_enable=0 and remain in the state until div_done==0 (minimum 1 cycle).
REQ-026 SHALL exit REL1 to DIV2 with div_a=q1, div_b=frame_slots and div_enable=1.
REQ-027 SHALL, in DIV2 on div_done=1, capture frame_cnt=div_quot and slot_idx=div_rem, then go to REL2; REL2 exits to RESP.
REQ-028 SHALL run a wait counter in DIV1 and DIV2 that clears on state entry and increments each cycle while div_done=0.
REQ-029 SHALL, when the wait counter reaches DIV_TIMEOUT, drop div_enable, set err=1, zero the data outputs and go to RESP; the divider is not waited on.
REQ-030 SHALL hold rsp_valid=1 and the outputs stable in RESP until rsp_ready=1, then return to IDLE on the next cycle.
REQ-031 SHALL keep err and the data outputs at their last values after leaving RESP; err clears on the next accept.
REQ-032 SHALL ignore req_valid in every state except IDLE.
REQ-033 SHALL use unsigned 32-bit arithmetic only, with no saturation.

Reset
REQ-034 SHALL, while rst_n=0 on a clock edge, force state=IDLE, req_ready=1 and rsp_valid=0, and set div_enable, div_a, div_b, frame_cnt, slot_idx, slot_off_us, err and the wait counter to 0.
REQ-035 SHALL abort any in-progress operation on reset without emitting a response; the divider sees div_enable=0 on the first cycle after reset.

Verification
REQ-036 SHALL pass this scenario: tsf=12345, slot_len=1000, frame_slots=8 with a behavioural divider -> rsp_valid with frame_cnt=1, slot_idx=4, slot_off_us=345, err=0.
REQ-037 SHALL pass this scenario: tsf=1000, slot_len=100, frame_slots=4 -> frame_cnt=2, slot_idx=2, slot_off=0; div_enable low for at least 1 cycle between the two divisions.
REQ-038 SHALL pass this scenario: slot_len=0 (or frame_slots=0) -> div_enable never rises; rsp_valid occurs 2 cycles after accept with err=1 and data 0.
REQ-039 SHALL pass this scenario: div_done tied 0 -> err=1 and rsp_valid occur 127 cycles after DIV1 entry; div_enable=0 in RESP.
REQ-040 SHALL pass this scenario: rsp_ready held 0 for 10 cycles, then 1 -> outputs stable throughout; req_ready=1 on the cycle after the handshake; a back-to-back second request completes correctly.
REQ-041 SHALL pass this scenario: rst_n pulsed low mid-DIV2 -> next cycle is IDLE with rsp_valid=0 and div_enable=0, and a following request gives a correct result.
